// File: rtl/mm_pkg.sv
// Shared types and constants for the 2x2 matrix-multiply sequencer.
// The load-order enum fixes the byte positions inside the operand register file.
package mm_pkg;

  localparam int DW = 8;
  localparam int RW = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLR,
    ST_FEED0,
    ST_FEED1,
    ST_WAIT,
    ST_EMIT
  } state_t;

  typedef enum logic [2:0] {
    LD_X00, LD_X01, LD_X10, LD_X11,
    LD_Y00, LD_Y01, LD_Y10, LD_Y11
  } ld_idx_t;

  function automatic logic [2:0] x_addr(input logic i, input logic k);
    return 3'(LD_X00) + {1'b0, i, k};
  endfunction

  function automatic logic [2:0] y_addr(input logic k, input logic j);
    return 3'(LD_Y00) + {1'b0, k, j};
  endfunction

endpackage

// File: rtl/mm_operand_rf.sv
// Eight-byte operand store: one load write port, combinational X[i][k] and Y[k][j] reads.
module mm_operand_rf
  import mm_pkg::*;
(
  input  logic          clk,
  input  logic          srst,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [1:0]    x_sel,
  input  logic [1:0]    y_sel,
  output logic [DW-1:0] x_data,
  output logic [DW-1:0] y_data
);

  logic [DW-1:0] byte_q [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_byte
      logic [DW-1:0] byte_reg;
      always_ff @(posedge clk) begin
        if (srst) begin
          byte_reg <= '0;
        end else if (wr_en && (wr_addr == 3'(gi))) begin
          byte_reg <= wr_data;
        end
      end
      assign byte_q[gi] = byte_reg;
    end
  endgenerate

  assign x_data = byte_q[x_addr(x_sel[1], x_sel[0])];
  assign y_data = byte_q[y_addr(y_sel[1], y_sel[0])];

endmodule

// File: rtl/matrix_mult_sequencer.sv
// Loads X and Y, drives the dot-product multiplier once per Z element and
// streams the four results out; every output is a register.
module matrix_mult_sequencer
  import mm_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LD_VALID,
  output logic                 LD_READY,
  input  logic signed [DW-1:0] LD_DATA,
  output logic                 MM_NRST,
  output logic                 MM_START,
  output logic signed [DW-1:0] MM_A,
  output logic signed [DW-1:0] MM_B,
  input  logic signed [RW-1:0] MM_OUT,
  input  logic                 MM_STROBE,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic signed [RW-1:0] RES_DATA,
  output logic [1:0]           RES_IDX,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR
);

  state_t                state_reg, state_next;
  logic [2:0]            ld_cnt_reg, ld_cnt_next;
  logic [1:0]            idx_reg, idx_next;
  logic [TW-1:0]         wait_cnt_reg, wait_cnt_next;
  logic                  ld_ready_reg, ld_ready_next;
  logic                  mm_nrst_reg, mm_nrst_next;
  logic                  mm_start_reg, mm_start_next;
  logic signed [DW-1:0]  mm_a_reg, mm_a_next;
  logic signed [DW-1:0]  mm_b_reg, mm_b_next;
  logic                  res_valid_reg, res_valid_next;
  logic signed [RW-1:0]  res_data_reg, res_data_next;
  logic [1:0]            res_idx_reg, res_idx_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;

  logic                  ld_fire;
  logic                  k_sel;
  logic [DW-1:0]         x_rd, y_rd;

  assign ld_fire = LD_VALID & ld_ready_reg;
  // Operands are fetched one cycle ahead: k=0 while heading into FEED0, k=1 into FEED1.
  assign k_sel   = (state_reg == ST_FEED0);

  mm_operand_rf u_rf (
    .clk     (CLK),
    .srst    (RST),
    .wr_en   (ld_fire),
    .wr_addr (ld_cnt_reg),
    .wr_data (LD_DATA),
    .x_sel   ({idx_reg[1], k_sel}),
    .y_sel   ({k_sel, idx_reg[0]}),
    .x_data  (x_rd),
    .y_data  (y_rd)
  );

  always_comb begin
    state_next     = state_reg;
    ld_cnt_next    = ld_cnt_reg;
    idx_next       = idx_reg;
    wait_cnt_next  = wait_cnt_reg;
    res_valid_next = res_valid_reg;
    res_data_next  = res_data_reg;
    res_idx_next   = res_idx_reg;
    err_next       = err_reg;
    done_next      = 1'b0;

    case (state_reg)
      ST_IDLE, ST_LOAD: begin
        if (ld_fire) begin
          ld_cnt_next = ld_cnt_reg + 3'd1;
          state_next  = ST_LOAD;
          if (state_reg == ST_IDLE) err_next = 1'b0;
          if (ld_cnt_reg == 3'd7) begin
            state_next = ST_CLR;
            idx_next   = 2'd0;
          end
        end
      end
      ST_CLR:   state_next = ST_FEED0;
      ST_FEED0: state_next = ST_FEED1;
      ST_FEED1: begin
        state_next    = ST_WAIT;
        wait_cnt_next = '0;
      end
      ST_WAIT: begin
        if (MM_STROBE) begin
          res_data_next  = MM_OUT;
          res_idx_next   = idx_reg;
          res_valid_next = 1'b1;
          state_next     = ST_EMIT;
        end else if (wait_cnt_reg == TW'(TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + TW'(1);
        end
      end
      ST_EMIT: begin
        if (RES_READY) begin
          res_valid_next = 1'b0;
          if (idx_reg == 2'd3) begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            idx_next   = idx_reg + 2'd1;
            state_next = ST_CLR;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Registered outputs are decoded from the state being entered.
    ld_ready_next = (state_next == ST_IDLE) || (state_next == ST_LOAD);
    busy_next     = (state_next != ST_IDLE);
    mm_nrst_next  = (state_next != ST_CLR);
    mm_start_next = (state_next == ST_FEED0) || (state_next == ST_FEED1) ||
                    (state_next == ST_WAIT);
    mm_a_next     = '0;
    mm_b_next     = '0;
    if ((state_next == ST_FEED0) || (state_next == ST_FEED1)) begin
      mm_a_next = x_rd;
      mm_b_next = y_rd;
    end else if (state_next == ST_WAIT) begin
      mm_a_next = mm_a_reg;
      mm_b_next = mm_b_reg;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      ld_cnt_reg    <= '0;
      idx_reg       <= '0;
      wait_cnt_reg  <= '0;
      ld_ready_reg  <= 1'b0;
      mm_nrst_reg   <= 1'b0;
      mm_start_reg  <= 1'b0;
      mm_a_reg      <= '0;
      mm_b_reg      <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_idx_reg   <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ld_cnt_reg    <= ld_cnt_next;
      idx_reg       <= idx_next;
      wait_cnt_reg  <= wait_cnt_next;
      ld_ready_reg  <= ld_ready_next;
      mm_nrst_reg   <= mm_nrst_next;
      mm_start_reg  <= mm_start_next;
      mm_a_reg      <= mm_a_next;
      mm_b_reg      <= mm_b_next;
      res_valid_reg <= res_valid_next;
      res_data_reg  <= res_data_next;
      res_idx_reg   <= res_idx_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  assign LD_READY  = ld_ready_reg;
  assign MM_NRST   = mm_nrst_reg;
  assign MM_START  = mm_start_reg;
  assign MM_A      = mm_a_reg;
  assign MM_B      = mm_b_reg;
  assign RES_VALID = res_valid_reg;
  assign RES_DATA  = res_data_reg;
  assign RES_IDX   = res_idx_reg;
  assign BUSY      = busy_reg;
  assign DONE      = done_reg;
  assign ERR       = err_reg;

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Self-checking bench: behavioural dot-product multiplier plus a matrix-product
// reference; random and directed jobs, back-pressure, timeout and mid-job reset.
module tb_matrix_mult_sequencer;

  localparam int TIMEOUT = 16;
  localparam int TW      = 5;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LD_VALID = 1'b0;
  logic        LD_READY;
  logic [7:0]  LD_DATA = '0;
  logic        MM_NRST, MM_START;
  logic [7:0]  MM_A, MM_B;
  logic [16:0] MM_OUT = '0;
  logic        MM_STROBE = 1'b0;
  logic        RES_VALID;
  logic        RES_READY = 1'b1;
  logic [16:0] RES_DATA;
  logic [1:0]  RES_IDX;
  logic        BUSY, DONE, ERR;

  matrix_mult_sequencer #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .CLK(CLK), .RST(RST),
    .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_DATA(LD_DATA),
    .MM_NRST(MM_NRST), .MM_START(MM_START), .MM_A(MM_A), .MM_B(MM_B),
    .MM_OUT(MM_OUT), .MM_STROBE(MM_STROBE),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA), .RES_IDX(RES_IDX),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Job operands in load order X00,X01,X10,X11,Y00,Y01,Y10,Y11.
  logic signed [7:0] job [8];

  function automatic int zexp(input int e);
    int i, j;
    i = e / 2;
    j = e % 2;
    return int'(job[2*i]) * int'(job[4+j]) + int'(job[2*i+1]) * int'(job[6+j]);
  endfunction

  // Behavioural multiplier: captures pair 0 when START rises, pair 1 next cycle,
  // strobes the sum three cycles after the pair-1 cycle.
  bit never_strobe = 1'b0;
  bit stray_strobe = 1'b0;
  int mm_phase = 0;
  int mm_cnt   = 0;
  int mm_acc   = 0;
  logic signed [7:0] a0, b0, a1, b1;

  always @(negedge CLK) begin
    MM_STROBE = 1'b0;
    if (RST || !MM_NRST) begin
      mm_phase = 0;
    end else begin
      case (mm_phase)
        0: if (MM_START) begin
          a0 = MM_A;
          b0 = MM_B;
          mm_phase = 1;
          if (stray_strobe) begin
            MM_STROBE = 1'b1;
            MM_OUT    = 17'h0BEEF;
          end
        end
        1: begin
          a1 = MM_A;
          b1 = MM_B;
          mm_acc = int'(a0) * int'(b0) + int'(a1) * int'(b1);
          mm_cnt = 0;
          mm_phase = 2;
        end
        2: begin
          mm_cnt++;
          if (mm_cnt == 3 && !never_strobe) begin
            MM_STROBE = 1'b1;
            MM_OUT    = 17'(mm_acc);
            mm_phase  = 3;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ld_ready"},  32'(LD_READY),  32'd0);
    check_eq({tag, "_mm_nrst"},   32'(MM_NRST),   32'd0);
    check_eq({tag, "_mm_start"},  32'(MM_START),  32'd0);
    check_eq({tag, "_mm_a"},      32'(MM_A),      32'd0);
    check_eq({tag, "_mm_b"},      32'(MM_B),      32'd0);
    check_eq({tag, "_res_valid"}, 32'(RES_VALID), 32'd0);
    check_eq({tag, "_res_data"},  32'(RES_DATA),  32'd0);
    check_eq({tag, "_res_idx"},   32'(RES_IDX),   32'd0);
    check_eq({tag, "_busy"},      32'(BUSY),      32'd0);
    check_eq({tag, "_done"},      32'(DONE),      32'd0);
    check_eq({tag, "_err"},       32'(ERR),       32'd0);
  endtask

  task automatic load_job(input bit gaps);
    int  b = 0;
    bit  err_chk = 1'b0;
    for (int cyc = 0; cyc < 200 && b < 8; cyc++) begin
      @(negedge CLK);
      if (err_chk) begin
        check_eq("err_clear_first_beat", 32'(ERR), 32'd0);
        err_chk = 1'b0;
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        LD_VALID = 1'b0;
      end else begin
        LD_VALID = 1'b1;
        LD_DATA  = job[b];
      end
      if (LD_VALID && LD_READY) begin
        b++;
        if (b == 1) err_chk = 1'b1;
      end
    end
    check_eq("load_beats", 32'(b), 32'd8);
  endtask

  task automatic collect_job(input int max_elems, input int stall_idx, input int stall_cycles);
    int got = 0, done_cnt = 0, low_cnt = 0, stall_left = stall_cycles;
    int clr_cyc = 0, cyc = 0, limit = 400;
    bit prev_nrst = 1'b1, prev_valid = 1'b0, nrst_ok = 1'b1;
    logic [16:0] e17;
    while (cyc < limit) begin
      @(negedge CLK);
      cyc++;
      LD_VALID = 1'b0;
      if (DONE) done_cnt++;
      if (!MM_NRST) begin
        low_cnt++;
        if (!prev_nrst) nrst_ok = 1'b0;
        clr_cyc = cyc;
      end
      if (RES_VALID && !prev_valid) check_eq("latency", 32'(cyc - clr_cyc), 32'd6);
      prev_nrst  = MM_NRST;
      prev_valid = RES_VALID;
      RES_READY  = 1'b1;
      if (RES_VALID && got < max_elems) begin
        if (int'(RES_IDX) == stall_idx && stall_left > 0) begin
          RES_READY = 1'b0;
          stall_left--;
          e17 = 17'(zexp(stall_idx));
          check_eq("hold_data",  32'(RES_DATA), 32'(e17));
          check_eq("hold_idx",   32'(RES_IDX),  32'(stall_idx));
          check_eq("hold_start", 32'(MM_START), 32'd0);
        end else begin
          e17 = 17'(zexp(got));
          check_eq("res_idx",  32'(RES_IDX),  32'(got));
          check_eq("res_data", 32'(RES_DATA), 32'(e17));
          $display("result idx=%0d data=%0d expected=%0d", RES_IDX, $signed(RES_DATA), zexp(got));
          got++;
          if (got == max_elems) begin
            if (max_elems < 4) return;
            limit = cyc + 2;
          end
        end
      end
    end
    check_eq("elements", 32'(got), 32'(max_elems));
    check_eq("done_pulses", 32'(done_cnt), 32'd1);
    check_eq("nrst_low_cycles", 32'(low_cnt), 32'd4);
    check_eq("nrst_pulse_width", 32'(nrst_ok), 32'd1);
    check_eq("idle_busy", 32'(BUSY), 32'd0);
    check_eq("idle_ld_ready", 32'(LD_READY), 32'd1);
  endtask

  task automatic random_job();
    for (int b = 0; b < 8; b++) job[b] = 8'($urandom);
  endtask

  initial begin
    int cyc, clr;
    bit saw_valid;

    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b0;
    @(negedge CLK);
    check_eq("ld_ready_after_reset", 32'(LD_READY), 32'd1);

    // Directed product.
    job = '{8'sd5, 8'sd10, 8'sd5, -8'sd10, 8'sd10, -8'sd10, 8'sd20, 8'sd20};
    load_job(1'b0);
    collect_job(4, -1, 0);

    // Extremes.
    for (int b = 0; b < 8; b++) job[b] = -8'sd128;
    load_job(1'b0);
    collect_job(4, -1, 0);
    for (int b = 0; b < 8; b++) job[b] = 8'sd127;
    load_job(1'b0);
    collect_job(4, -1, 0);

    // Back-pressure at idx 1.
    random_job();
    load_job(1'b0);
    collect_job(4, 1, 5);

    // Load gaps and stray strobes during FEED0.
    repeat (3) begin
      random_job();
      stray_strobe = 1'b1;
      load_job(1'b1);
      collect_job(4, -1, 0);
      stray_strobe = 1'b0;
    end

    // Timeout.
    never_strobe = 1'b1;
    random_job();
    load_job(1'b0);
    cyc = 0;
    clr = -1;
    saw_valid = 1'b0;
    while (cyc < 100 && !ERR) begin
      @(negedge CLK);
      cyc++;
      LD_VALID = 1'b0;
      if (!MM_NRST && clr < 0) clr = cyc;
      if (RES_VALID) saw_valid = 1'b1;
    end
    check_eq("timeout_err", 32'(ERR), 32'd1);
    check_eq("timeout_cycles", 32'(cyc - clr), 32'(3 + TIMEOUT));
    check_eq("timeout_no_valid", 32'(saw_valid), 32'd0);
    check_eq("timeout_idle", 32'(BUSY), 32'd0);
    check_eq("timeout_ld_ready", 32'(LD_READY), 32'd1);
    $display("timeout ERR=%0d after %0d cycles", ERR, cyc - clr);
    never_strobe = 1'b0;
    random_job();
    load_job(1'b1);
    collect_job(4, -1, 0);

    // Reset during WAIT of idx 2.
    random_job();
    load_job(1'b0);
    collect_job(2, -1, 0);
    repeat (4) @(negedge CLK);
    check_eq("in_wait_start", 32'(MM_START), 32'd1);
    check_eq("in_wait_busy", 32'(BUSY), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check_reset_outputs("midjob_reset");
    RST = 1'b0;
    @(negedge CLK);
    check_eq("ld_ready_after_midjob_reset", 32'(LD_READY), 32'd1);
    random_job();
    load_job(1'b1);
    collect_job(4, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
